// File: rtl/i2s_receiver.sv
// rtl/i2s_receiver.sv - I2S receive deserialiser into 16-bit stereo sample pairs
module i2s_receiver #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_clk,
    input  logic                    bit_clk,
    input  logic                    sdata,
    output logic [SAMPLE_WIDTH-1:0] sample_left,
    output logic [SAMPLE_WIDTH-1:0] sample_right,
    output logic                    valid,
    output logic                    locked,
    output logic                    frame_error
);

    localparam int CW = $clog2(SAMPLE_WIDTH + 1);
    localparam logic [CW-1:0] FULL      = CW'(SAMPLE_WIDTH);
    localparam logic [CW-1:0] LAST_SLOT = CW'(SAMPLE_WIDTH - 1);

    typedef enum logic [0:0] {
        WAIT_SYNC,
        RECEIVE
    } state_t;

    state_t                  state_q;
    logic [SYNC_STAGES-1:0]  bclk_sync_q;
    logic [SYNC_STAGES-1:0]  ws_sync_q;
    logic [SYNC_STAGES-1:0]  data_sync_q;
    logic                    bclk_prev_q;
    logic                    ws_prev_q;
    logic                    primed_q;
    logic [CW-1:0]           bitcnt_q;
    logic [SAMPLE_WIDTH-1:0] shreg_q;
    logic [SAMPLE_WIDTH-1:0] left_hold_q;
    logic                    pending_q;
    logic [SAMPLE_WIDTH-1:0] sample_left_q;
    logic [SAMPLE_WIDTH-1:0] sample_right_q;
    logic                    valid_q;
    logic                    locked_q;
    logic                    frame_error_q;

    logic                    bclk_s;
    logic                    ws_s;
    logic                    data_s;
    logic                    bit_event;
    logic                    boundary;
    logic                    word_long_enough;
    logic [SAMPLE_WIDTH-1:0] shreg_d;
    logic [SAMPLE_WIDTH-1:0] word_d;

    assign bclk_s           = bclk_sync_q[SYNC_STAGES-1];
    assign ws_s             = ws_sync_q[SYNC_STAGES-1];
    assign data_s           = data_sync_q[SYNC_STAGES-1];
    assign bit_event        = bclk_s & ~bclk_prev_q;
    assign boundary         = ws_s ^ ws_prev_q;
    assign word_long_enough = (bitcnt_q >= LAST_SLOT);
    assign shreg_d          = {shreg_q[SAMPLE_WIDTH-2:0], data_s};

    // Completed word: include this event's bit only while still inside the first SAMPLE_WIDTH bits
    always_comb begin
        word_d = shreg_q;
        if (bitcnt_q < FULL) begin
            word_d = shreg_d;
        end
    end

    // Synchronisers, bit_clk edge detect and the lock/receive state machine
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= WAIT_SYNC;
            bclk_sync_q    <= '0;
            ws_sync_q      <= '0;
            data_sync_q    <= '0;
            bclk_prev_q    <= 1'b0;
            ws_prev_q      <= 1'b0;
            primed_q       <= 1'b0;
            bitcnt_q       <= '0;
            shreg_q        <= '0;
            left_hold_q    <= '0;
            pending_q      <= 1'b0;
            sample_left_q  <= '0;
            sample_right_q <= '0;
            valid_q        <= 1'b0;
            locked_q       <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            bclk_sync_q   <= {bclk_sync_q[SYNC_STAGES-2:0], bit_clk};
            ws_sync_q     <= {ws_sync_q[SYNC_STAGES-2:0], frame_clk};
            data_sync_q   <= {data_sync_q[SYNC_STAGES-2:0], sdata};
            bclk_prev_q   <= bclk_s;
            valid_q       <= 1'b0;
            frame_error_q <= 1'b0;
            if (bit_event) begin
                ws_prev_q <= ws_s;
                case (state_q)
                    WAIT_SYNC: begin
                        // The first event after reset only learns the current word select, so
                        // lock waits for a genuine frame_clk transition rather than the reset value.
                        if (!primed_q) begin
                            primed_q <= 1'b1;
                        end else if (boundary) begin
                            state_q  <= RECEIVE;
                            locked_q <= 1'b1;
                            bitcnt_q <= '0;
                            shreg_q  <= '0;
                        end
                    end
                    RECEIVE: begin
                        if (boundary) begin
                            bitcnt_q <= '0;
                            shreg_q  <= '0;
                            if (word_long_enough) begin
                                if (!ws_prev_q) begin
                                    left_hold_q <= word_d;
                                    pending_q   <= 1'b1;
                                end else if (pending_q) begin
                                    sample_left_q  <= left_hold_q;
                                    sample_right_q <= word_d;
                                    valid_q        <= 1'b1;
                                    pending_q      <= 1'b0;
                                end
                            end else begin
                                frame_error_q <= 1'b1;
                                pending_q     <= 1'b0;
                            end
                        end else if (bitcnt_q < FULL) begin
                            shreg_q  <= shreg_d;
                            bitcnt_q <= bitcnt_q + 1'b1;
                        end
                    end
                    default: state_q <= WAIT_SYNC;
                endcase
            end
        end
    end

    assign sample_left  = sample_left_q;
    assign sample_right = sample_right_q;
    assign valid        = valid_q;
    assign locked       = locked_q;
    assign frame_error  = frame_error_q;

endmodule
